// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the load-hazard controller.
// Holds the register-file size, default load depth and the NOP encoding.
package hazard_ctrl_pkg;
    localparam int          NUM_REGS   = 32;
    localparam int          MAX_LD_DEF = 2;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [4:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction
endpackage

// File: rtl/scoreboard.sv
// Purpose: per-register pending-load bitmap with outstanding-load counter and sticky error.
// Latency: set/clear visible one edge after the request; no backpressure, set wins over clear.
// Backpressure: none, the caller guarantees it never issues beyond capacity.
module scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [4:0]          set_idx,
    input  logic                ret_vld,
    input  logic [4:0]          ret_idx,
    output logic [NUM_REGS-1:0] busy,
    output logic [1:0]          ld_cnt,
    output logic                err
);
    logic                ret_hit;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign ret_hit  = ret_vld && busy[ret_idx];
    assign set_mask = set_en  ? onehot(set_idx) : '0;
    assign clr_mask = ret_hit ? onehot(ret_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            ld_cnt <= '0;
            err    <= 1'b0;
        end else begin
            // clear first, then set, so a same-index return and reissue stays busy
            busy   <= (busy & ~clr_mask) | set_mask;
            ld_cnt <= ld_cnt + 2'(set_en) - 2'(ret_hit);
            if (ret_vld && !ret_hit)
                err <= 1'b1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: detects RAW/WAW/capacity hazards on outstanding loads and prioritises jump flushes.
// Latency: stall/bubble/flush are combinational (zero cycle); scoreboard updates at the next edge.
// Backpressure: HC_stall holds PC/IF/ID; all outputs forced low while rst is high.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_LD = MAX_LD_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                ID_vld,
    input  logic [4:0]          ID_rs1,
    input  logic [4:0]          ID_rs2,
    input  logic                ID_rs1_use,
    input  logic                ID_rs2_use,
    input  logic [4:0]          ID_rd,
    input  logic                ID_rd_vld,
    input  logic                ID_is_load,
    input  logic                EX_jump,
    input  logic                MEM_ld_done,
    input  logic [4:0]          MEM_ld_rd,
    output logic                HC_stall,
    output logic                HC_bubble_ex,
    output logic                HC_flush_id,
    output logic [NUM_REGS-1:0] HC_busy,
    output logic [1:0]          HC_ld_cnt,
    output logic                HC_err
);
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] eff_busy;
    logic                ret_hit;
    logic                raw_haz;
    logic                waw_haz;
    logic                cap_haz;
    logic                any_haz;
    logic                issue;

    // a load returning this cycle no longer blocks its consumers
    assign clr_mask = MEM_ld_done ? onehot(MEM_ld_rd) : '0;
    assign eff_busy = HC_busy & ~clr_mask;
    assign ret_hit  = MEM_ld_done && HC_busy[MEM_ld_rd];

    assign raw_haz = ID_vld && ((ID_rs1_use && eff_busy[ID_rs1]) ||
                                (ID_rs2_use && eff_busy[ID_rs2]));
    assign waw_haz = ID_vld && ID_rd_vld && eff_busy[ID_rd];
    assign cap_haz = ID_vld && ID_is_load &&
                     (({1'b0, HC_ld_cnt} - {2'b00, ret_hit}) == 3'(MAX_LD));
    assign any_haz = raw_haz || waw_haz || cap_haz;

    always_comb begin
        HC_stall     = 1'b0;
        HC_bubble_ex = 1'b0;
        HC_flush_id  = 1'b0;
        if (!rst) begin
            if (EX_jump) begin
                HC_flush_id  = 1'b1;
                HC_bubble_ex = 1'b1;
            end else begin
                HC_stall     = any_haz;
                HC_bubble_ex = any_haz;
            end
        end
    end

    assign issue = ID_vld && ID_is_load && ID_rd_vld && (ID_rd != 5'd0) &&
                   !HC_stall && !EX_jump;

    scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue),
        .set_idx (ID_rd),
        .ret_vld (MEM_ld_done),
        .ret_idx (MEM_ld_rd),
        .busy    (HC_busy),
        .ld_cnt  (HC_ld_cnt),
        .err     (HC_err)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios followed by random traffic, checked against a pending-register model.
module tb_hazard_ctrl;
    localparam int MAXL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_vld, ID_rs1_use, ID_rs2_use, ID_rd_vld, ID_is_load;
    logic [4:0]  ID_rs1, ID_rs2, ID_rd, MEM_ld_rd;
    logic        EX_jump, MEM_ld_done;
    logic        HC_stall, HC_bubble_ex, HC_flush_id, HC_err;
    logic [31:0] HC_busy;
    logic [1:0]  HC_ld_cnt;

    int errors = 0;
    int checks = 0;

    // reference state: which registers have a load in flight, plus sticky error
    bit m_pend[32];
    bit m_err;

    hazard_ctrl #(.MAX_LD(MAXL)) dut (
        .clk(clk), .rst(rst),
        .ID_vld(ID_vld), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rs1_use(ID_rs1_use), .ID_rs2_use(ID_rs2_use),
        .ID_rd(ID_rd), .ID_rd_vld(ID_rd_vld), .ID_is_load(ID_is_load),
        .EX_jump(EX_jump), .MEM_ld_done(MEM_ld_done), .MEM_ld_rd(MEM_ld_rd),
        .HC_stall(HC_stall), .HC_bubble_ex(HC_bubble_ex), .HC_flush_id(HC_flush_id),
        .HC_busy(HC_busy), .HC_ld_cnt(HC_ld_cnt), .HC_err(HC_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic idle();
        ID_vld = 0; ID_rs1 = 0; ID_rs2 = 0; ID_rs1_use = 0; ID_rs2_use = 0;
        ID_rd = 0; ID_rd_vld = 0; ID_is_load = 0;
        EX_jump = 0; MEM_ld_done = 0; MEM_ld_rd = 0;
    endtask

    task automatic id_insn(input bit ld, input int rs1, input bit u1,
                           input int rs2, input bit u2, input int rd, input bit rdv);
        ID_vld = 1; ID_is_load = ld;
        ID_rs1 = 5'(rs1); ID_rs1_use = u1;
        ID_rs2 = 5'(rs2); ID_rs2_use = u2;
        ID_rd  = 5'(rd);  ID_rd_vld  = rdv;
    endtask

    // one clock: compare against the model at negedge, advance model at posedge
    task automatic cyc(input string tag);
        bit ret, blk1, blk2, blkd, haz, e_st, e_bu, e_fl, iss;
        int n;
        @(negedge clk);
        n    = m_count();
        ret  = MEM_ld_done && m_pend[MEM_ld_rd];
        blk1 = m_pend[ID_rs1] && !(MEM_ld_done && MEM_ld_rd == ID_rs1);
        blk2 = m_pend[ID_rs2] && !(MEM_ld_done && MEM_ld_rd == ID_rs2);
        blkd = m_pend[ID_rd]  && !(MEM_ld_done && MEM_ld_rd == ID_rd);
        haz  = ID_vld && ((ID_rs1_use && blk1) || (ID_rs2_use && blk2) ||
                          (ID_rd_vld && blkd) ||
                          (ID_is_load && (n - int'(ret)) == MAXL));
        e_st = 0; e_bu = 0; e_fl = 0;
        if (!rst) begin
            if (EX_jump) begin e_fl = 1; e_bu = 1; end
            else begin e_st = haz; e_bu = haz; end
        end
        chk({tag, ".stall"},  32'(HC_stall),     32'(e_st));
        chk({tag, ".bubble"}, 32'(HC_bubble_ex), 32'(e_bu));
        chk({tag, ".flush"},  32'(HC_flush_id),  32'(e_fl));
        chk({tag, ".busy"},   HC_busy,           m_vec());
        chk({tag, ".cnt"},    32'(HC_ld_cnt),    32'(n));
        chk({tag, ".err"},    32'(HC_err),       32'(m_err));
        iss = ID_vld && ID_is_load && ID_rd_vld && ID_rd != 0 && !e_st && !EX_jump;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
            m_err = 0;
        end else begin
            if (ret) m_pend[MEM_ld_rd] = 0;
            else if (MEM_ld_done) m_err = 1;
            if (iss) m_pend[ID_rd] = 1;
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        m_err = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        @(posedge clk); #1;
        cyc("reset");
        rst = 0;

        // load-use on x5
        id_insn(1, 2, 1, 0, 0, 5, 1);          cyc("lu_issue");
        id_insn(0, 5, 1, 1, 1, 6, 1);          #1; chk("lu_stall_now", 32'(HC_stall), 32'd1);
        cyc("lu_wait0"); cyc("lu_wait1"); cyc("lu_wait2");
        MEM_ld_done = 1; MEM_ld_rd = 5;        #1; chk("lu_release", 32'(HC_stall), 32'd0);
        cyc("lu_ret");

        // capacity with two loads in flight
        idle(); id_insn(1, 0, 0, 0, 0, 1, 1);  cyc("cap_ld1");
        id_insn(1, 0, 0, 0, 0, 2, 1);          cyc("cap_ld2");
        chk("cap_cnt2", 32'(HC_ld_cnt), 32'd2);
        id_insn(1, 0, 0, 0, 0, 3, 1);          #1; chk("cap_stall", 32'(HC_stall), 32'd1);
        cyc("cap_blocked");
        MEM_ld_done = 1; MEM_ld_rd = 1;        #1; chk("cap_release", 32'(HC_stall), 32'd0);
        cyc("cap_swap");
        chk("cap_cnt_after", 32'(HC_ld_cnt), 32'd2);
        chk("cap_busy_after", HC_busy, 32'h0000_000C);

        // jump outranks a RAW hazard on x2
        idle(); id_insn(0, 2, 1, 0, 0, 4, 1); EX_jump = 1;
        #1; chk("jmp_flush", 32'(HC_flush_id), 32'd1);
        chk("jmp_nostall", 32'(HC_stall), 32'd0);
        cyc("jmp");
        chk("jmp_busy", HC_busy, 32'h0000_000C);

        // same-rd return and reissue on x7
        idle(); MEM_ld_done = 1; MEM_ld_rd = 2; cyc("x7_free");
        idle(); id_insn(1, 0, 0, 0, 0, 7, 1);   cyc("x7_issue");
        MEM_ld_done = 1; MEM_ld_rd = 7;         cyc("x7_collide");
        chk("x7_busy", 32'(HC_busy[7]), 32'd1);
        chk("x7_cnt", 32'(HC_ld_cnt), 32'd2);

        // unmatched return sets sticky error
        idle(); MEM_ld_done = 1; MEM_ld_rd = 9; cyc("err_set");
        idle(); cyc("err_hold");
        chk("err_sticky", 32'(HC_err), 32'd1);

        // reset with two loads pending and a hazard plus jump present
        rst = 1; id_insn(0, 3, 1, 0, 0, 4, 1); EX_jump = 1;
        #1; chk("rst_outs", {29'd0, HC_stall, HC_bubble_ex, HC_flush_id}, 32'd0);
        cyc("rst_mid");
        rst = 0; idle();
        chk("rst_busy", HC_busy, 32'd0);
        chk("rst_cnt", 32'(HC_ld_cnt), 32'd0);
        id_insn(1, 0, 0, 0, 0, 0, 1);          cyc("x0_load");
        chk("x0_busy", HC_busy, 32'd0);
        idle(); MEM_ld_done = 1; MEM_ld_rd = 3; cyc("stale_ret");
        chk("stale_err", 32'(HC_err), 32'd1);

        // random traffic on a small register window to force collisions
        for (int k = 0; k < 500; k++) begin
            rst         = ($urandom_range(0, 59) == 0);
            ID_vld      = ($urandom_range(0, 3) != 0);
            ID_is_load  = ($urandom_range(0, 1) == 1);
            ID_rs1      = 5'($urandom_range(0, 7));
            ID_rs2      = 5'($urandom_range(0, 7));
            ID_rs1_use  = ($urandom_range(0, 1) == 1);
            ID_rs2_use  = ($urandom_range(0, 1) == 1);
            ID_rd       = 5'($urandom_range(0, 7));
            ID_rd_vld   = ($urandom_range(0, 4) != 0);
            EX_jump     = ($urandom_range(0, 7) == 0);
            MEM_ld_done = ($urandom_range(0, 2) == 0);
            MEM_ld_rd   = 5'($urandom_range(0, 7));
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
